// File: rtl/serdes_pkg.sv
// Shared PAM4 constants, slicer decision and saturating arithmetic for the
// receive-side BER checker.
package serdes_pkg;

    localparam logic signed [7:0] PAM4_LVL_N96 = -8'sd96;
    localparam logic signed [7:0] PAM4_LVL_N32 = -8'sd32;
    localparam logic signed [7:0] PAM4_LVL_P32 = 8'sd32;
    localparam logic signed [7:0] PAM4_LVL_P96 = 8'sd96;

    localparam logic signed [7:0] TH_LOW  = -8'sd64;
    localparam logic signed [7:0] TH_MID  = 8'sd0;
    localparam logic signed [7:0] TH_HIGH = 8'sd64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ber_state_t;

    // Gray-coded decision: 00 < 01 < 11 < 10 in amplitude order
    function automatic logic [1:0] pam4_slice(input logic signed [7:0] sample);
        if (sample < TH_LOW)       return 2'b00;
        else if (sample < TH_MID)  return 2'b01;
        else if (sample < TH_HIGH) return 2'b11;
        else                       return 2'b10;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/ref_fifo.sv
// Alignment FIFO for the transmitted symbol stream; show-ahead head output so
// a compare can use the head in the same cycle it is popped.
module ref_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop on a full FIFO frees the slot the simultaneous push lands in
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign dout = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pam4_ber_checker.sv
// PAM4 slicer plus windowed symbol/bit error counting against a buffered
// copy of the transmitted symbol stream.
module pam4_ber_checker
    import serdes_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MEAS_LEN   = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              clear,
    input  logic [1:0]        tx_symbol,
    input  logic              tx_symbol_valid,
    input  logic signed [7:0] rx_sample,
    input  logic              rx_sample_valid,
    output logic [1:0]        rx_symbol,
    output logic              rx_symbol_valid,
    output logic [31:0]       symbol_count,
    output logic [31:0]       symbol_errors,
    output logic [31:0]       bit_errors,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [31:0] LAST_CNT = 32'(MEAS_LEN - 1);

    ber_state_t  r_state;
    ber_state_t  w_state_next;
    logic [1:0]  r_rx_symbol;
    logic        r_rx_valid;
    logic [31:0] r_symbol_count;
    logic [31:0] r_symbol_errors;
    logic [31:0] r_bit_errors;
    logic        r_overflow;
    logic        r_underflow;

    logic        w_run;
    logic [1:0]  w_slice;
    logic        w_push;
    logic        w_compare;
    logic [1:0]  w_fifo_head;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [1:0]  w_diff;
    logic [1:0]  w_bit_err;

    assign w_run     = (r_state == RUN) & ~clear;
    assign w_slice   = pam4_slice(rx_sample);
    assign w_push    = w_run & tx_symbol_valid;
    assign w_compare = w_run & rx_sample_valid & ~w_fifo_empty;
    assign w_diff    = w_slice ^ w_fifo_head;
    assign w_bit_err = {w_diff[1] & w_diff[0], w_diff[1] ^ w_diff[0]};

    ref_fifo #(
        .WIDTH (2),
        .DEPTH (FIFO_DEPTH)
    ) u_ref_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (clear),
        .push  (w_push),
        .pop   (w_compare),
        .din   (tx_symbol),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_compare && (r_symbol_count == LAST_CNT)) w_state_next = DONE;
            DONE:    w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
        if (clear) w_state_next = IDLE;
    end

    // The slicer runs in every state; only compares are gated by RUN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_symbol <= 2'b00;
            r_rx_valid  <= 1'b0;
        end else begin
            r_rx_valid <= rx_sample_valid;
            if (rx_sample_valid) r_rx_symbol <= w_slice;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_symbol_count  <= '0;
            r_symbol_errors <= '0;
            r_bit_errors    <= '0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
        end else if (clear) begin
            r_symbol_count  <= '0;
            r_symbol_errors <= '0;
            r_bit_errors    <= '0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
        end else begin
            if (w_compare) begin
                r_symbol_count <= sat_add(r_symbol_count, 2'd1);
                if (w_diff != 2'b00) r_symbol_errors <= sat_add(r_symbol_errors, 2'd1);
                r_bit_errors <= sat_add(r_bit_errors, w_bit_err);
            end
            if (w_run && rx_sample_valid && w_fifo_empty) r_underflow <= 1'b1;
            if (w_push && w_fifo_full && !w_compare)      r_overflow  <= 1'b1;
        end
    end

    assign rx_symbol       = r_rx_symbol;
    assign rx_symbol_valid = r_rx_valid;
    assign symbol_count    = r_symbol_count;
    assign symbol_errors   = r_symbol_errors;
    assign bit_errors      = r_bit_errors;
    assign busy            = (r_state == RUN);
    assign done            = (r_state == DONE);
    assign overflow        = r_overflow;
    assign underflow       = r_underflow;

endmodule
